// File: rtl/row_deserializer_pkg.sv
// Shared pixel-sensor configuration: array geometry, receive FSM states
// and the row word type used by downstream frame storage.
package PixelSensorConfig;

   localparam int PIXEL_ARRAY_WIDTH = 8;
   localparam int OUTPUT_BUS_WIDTH  = 2;
   localparam int PIXEL_BITS        = 8;

   typedef enum logic {
      RX_IDLE,
      RX_RECEIVING
   } rx_state_t;

   typedef logic [PIXEL_ARRAY_WIDTH-1:0][PIXEL_BITS-1:0] row_t;

endpackage

// File: rtl/counter.sv
// Generic up-counter with synchronous clear; clear wins over enable.
// Wraps at 2**W.
module Counter #(
   parameter int W = 4
) (
   input  logic         CLK,
   input  logic         RESET,
   input  logic         clear,
   input  logic         enable,
   output logic [W-1:0] count
);

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (enable) begin
         count <= count + W'(1);
      end
   end

endmodule

// File: rtl/row_deserializer_bus_beat_sync.sv
// Brings the gated bus clock and bus data into the CLK domain and emits
// a one-cycle beat strobe with the data word aligned to it.
module bus_beat_sync #(
   parameter int W = 16
) (
   input  logic         CLK,
   input  logic         RESET,
   input  logic         bus_clk,
   input  logic [W-1:0] bus_data,
   output logic         beat,
   output logic [W-1:0] beat_data
);

   logic         s1, s2, s3;
   logic [W-1:0] d1, d2;

   // Data runs through the same two stages as bus_clk, so d2 is the word
   // that was stable when s2 first saw the rising edge.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         s1        <= 1'b0;
         s2        <= 1'b0;
         s3        <= 1'b0;
         d1        <= '0;
         d2        <= '0;
         beat      <= 1'b0;
         beat_data <= '0;
      end else begin
         s1   <= bus_clk;
         s2   <= s1;
         s3   <= s2;
         d1   <= bus_data;
         d2   <= d1;
         beat <= s2 & ~s3;
         if (s2 & ~s3) begin
            beat_data <= d2;
         end
      end
   end

endmodule

// File: rtl/row_deserializer.sv
// Reassembles bus beats into pixel rows and hands them out on a
// ready/valid port in the CLK domain, with timeout abort and overflow flag.
module row_deserializer #(
   parameter int PIXEL_ARRAY_WIDTH = PixelSensorConfig::PIXEL_ARRAY_WIDTH,
   parameter int OUTPUT_BUS_WIDTH  = PixelSensorConfig::OUTPUT_BUS_WIDTH,
   parameter int PIXEL_BITS        = PixelSensorConfig::PIXEL_BITS,
   parameter int IDLE_TIMEOUT      = 16
) (
   input  logic                                         CLK,
   input  logic                                         RESET,
   input  logic                                         BUS_CLK,
   input  logic [OUTPUT_BUS_WIDTH*PIXEL_BITS-1:0]       BUS_DATA,
   output logic [PIXEL_ARRAY_WIDTH-1:0][PIXEL_BITS-1:0] ROW_DATA,
   output logic                                         ROW_VALID,
   input  logic                                         ROW_READY,
   output logic                                         ROW_ERROR,
   output logic                                         ROW_OVERFLOW,
   output logic                                         BUS_ACTIVE
);

   import PixelSensorConfig::*;

   localparam int ROW_WORDS = PIXEL_ARRAY_WIDTH / OUTPUT_BUS_WIDTH;
   localparam int BW        = OUTPUT_BUS_WIDTH * PIXEL_BITS;
   localparam int CW        = (ROW_WORDS > 1) ? $clog2(ROW_WORDS) : 1;
   localparam int TW        = $clog2(IDLE_TIMEOUT + 1);

   localparam logic [CW-1:0] LAST_BEAT = CW'(ROW_WORDS - 1);
   localparam logic [TW-1:0] TMO_LAST  = TW'(IDLE_TIMEOUT - 1);

   logic                         beat;
   logic [BW-1:0]                beat_data;
   rx_state_t                    state, state_n;
   logic [CW-1:0]                cnt;
   logic                         cnt_clr, cnt_inc;
   logic [TW-1:0]                idle_cnt, idle_n;
   logic                         row_done, done_n;
   logic                         err_n;
   logic                         wr_en;
   logic [CW-1:0]                wr_idx;
   logic [ROW_WORDS-1:0][BW-1:0] asm_buf;

   bus_beat_sync #(
      .W(BW)
   ) u_sync (
      .CLK      (CLK),
      .RESET    (RESET),
      .bus_clk  (BUS_CLK),
      .bus_data (BUS_DATA),
      .beat     (beat),
      .beat_data(beat_data)
   );

   Counter #(
      .W(CW)
   ) u_beat_cnt (
      .CLK   (CLK),
      .RESET (RESET),
      .clear (cnt_clr),
      .enable(cnt_inc),
      .count (cnt)
   );

   always_comb begin
      state_n = state;
      cnt_clr = 1'b0;
      cnt_inc = 1'b0;
      idle_n  = idle_cnt;
      done_n  = 1'b0;
      err_n   = 1'b0;
      wr_en   = 1'b0;
      wr_idx  = cnt;
      unique case (state)
         RX_IDLE: begin
            idle_n = '0;
            if (beat) begin
               wr_en  = 1'b1;
               wr_idx = '0;
               if (ROW_WORDS == 1) begin
                  done_n = 1'b1;
               end else begin
                  cnt_inc = 1'b1;
                  state_n = RX_RECEIVING;
               end
            end
         end
         RX_RECEIVING: begin
            if (beat) begin
               wr_en  = 1'b1;
               idle_n = '0;
               if (cnt == LAST_BEAT) begin
                  done_n  = 1'b1;
                  cnt_clr = 1'b1;
                  state_n = RX_IDLE;
               end else begin
                  cnt_inc = 1'b1;
               end
            end else if (idle_cnt == TMO_LAST) begin
               err_n   = 1'b1;
               cnt_clr = 1'b1;
               idle_n  = '0;
               state_n = RX_IDLE;
            end else begin
               idle_n = idle_cnt + TW'(1);
            end
         end
      endcase
   end

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state     <= RX_IDLE;
         idle_cnt  <= '0;
         row_done  <= 1'b0;
         ROW_ERROR <= 1'b0;
         asm_buf   <= '0;
      end else begin
         state     <= state_n;
         idle_cnt  <= idle_n;
         row_done  <= done_n;
         ROW_ERROR <= err_n;
         if (wr_en) begin
            asm_buf[wr_idx] <= beat_data;
         end
      end
   end

   // A finished row may enter the holding register in the same cycle the
   // consumer drains it; otherwise it is lost and the loss is remembered.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         ROW_DATA     <= '0;
         ROW_VALID    <= 1'b0;
         ROW_OVERFLOW <= 1'b0;
      end else if (row_done && (!ROW_VALID || ROW_READY)) begin
         ROW_DATA  <= asm_buf;
         ROW_VALID <= 1'b1;
      end else begin
         if (row_done) begin
            ROW_OVERFLOW <= 1'b1;
         end
         if (ROW_READY) begin
            ROW_VALID <= 1'b0;
         end
      end
   end

   assign BUS_ACTIVE = (state == RX_RECEIVING);

endmodule

// File: tb/tb_row_deserializer.sv
// Directed bench for row_deserializer: 8 pixels x 8 bits, 2 pixels per
// beat, bus clock at one tenth of CLK.
module tb_row_deserializer;

   logic                     clk = 1'b0;
   logic                     reset;
   logic                     bus_clk;
   logic [15:0]              bus_data;
   PixelSensorConfig::row_t  row_data;
   logic                     row_valid;
   logic                     row_ready;
   logic                     row_error;
   logic                     row_overflow;
   logic                     bus_active;

   row_deserializer #(
      .PIXEL_ARRAY_WIDTH(8),
      .OUTPUT_BUS_WIDTH (2),
      .PIXEL_BITS       (8),
      .IDLE_TIMEOUT     (16)
   ) dut (
      .CLK         (clk),
      .RESET       (reset),
      .BUS_CLK     (bus_clk),
      .BUS_DATA    (bus_data),
      .ROW_DATA    (row_data),
      .ROW_VALID   (row_valid),
      .ROW_READY   (row_ready),
      .ROW_ERROR   (row_error),
      .ROW_OVERFLOW(row_overflow),
      .BUS_ACTIVE  (bus_active)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] beats [4];
      logic [63:0] row;
   } vec_t;

   vec_t        tv [4];
   int          cyc = 0;
   int          rise_cyc = 0;
   int          vr_cyc = -1;
   int          err_cyc = -1;
   int          err_pulses = 0;
   logic        prev_valid = 1'b0;
   logic [63:0] got [$];
   int          n_pass = 0;
   int          n_total = 0;

   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge clk) begin
      #1;
      if (row_valid && !prev_valid) vr_cyc = cyc;
      prev_valid = row_valid;
      if (row_error) begin
         err_pulses++;
         err_cyc = cyc;
      end
      if (row_valid && row_ready) got.push_back(row_data);
   end

   initial begin
      #3ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic check(input string nm, input logic [63:0] act,
                        input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", nm, act, exp);
   endtask

   task automatic rise_beat(input logic [15:0] d);
      bus_data = d;
      repeat (5) @(negedge clk);
      bus_clk  = 1'b1;
      rise_cyc = cyc;
   endtask

   task automatic fall_beat();
      repeat (5) @(negedge clk);
      bus_clk = 1'b0;
   endtask

   task automatic send_beat(input logic [15:0] d);
      rise_beat(d);
      fall_beat();
   endtask

   task automatic send_row(input int k);
      for (int i = 0; i < 4; i++) send_beat(tv[k].beats[i]);
   endtask

   initial begin
      tv[0].beats = '{16'h0100, 16'h0302, 16'h0504, 16'h0706};
      tv[0].row   = 64'h0706050403020100;
      tv[1].beats = '{16'h1110, 16'h1312, 16'h1514, 16'h1716};
      tv[1].row   = 64'h1716151413121110;
      tv[2].beats = '{16'hBBAA, 16'hDDCC, 16'hFFEE, 16'h2211};
      tv[2].row   = 64'h2211FFEEDDCCBBAA;
      tv[3].beats = '{16'h0000, 16'hFFFF, 16'h8001, 16'h7F80};
      tv[3].row   = 64'h7F808001FFFF0000;

      reset     = 1'b1;
      bus_clk   = 1'b0;
      bus_data  = '0;
      row_ready = 1'b0;
      repeat (3) @(negedge clk);
      check("reset_valid", 64'(row_valid), 64'd0);
      check("reset_data", row_data, 64'd0);
      check("reset_error", 64'(row_error), 64'd0);
      check("reset_overflow", 64'(row_overflow), 64'd0);
      check("reset_active", 64'(bus_active), 64'd0);
      reset = 1'b0;
      repeat (2) @(negedge clk);

      // 1: single row, latency from final bus rise
      send_row(0);
      repeat (3) @(negedge clk);
      check("t1_latency", 64'(vr_cyc - rise_cyc - 1), 64'd4);
      check("t1_valid", 64'(row_valid), 64'd1);
      check("t1_data", row_data, tv[0].row);
      check("t1_error", 64'(err_pulses), 64'd0);
      check("t1_active", 64'(bus_active), 64'd0);

      // 2: consumer stalled, later rows dropped
      send_row(1);
      repeat (3) @(negedge clk);
      check("t2_overflow", 64'(row_overflow), 64'd1);
      check("t2_hold_data", row_data, tv[0].row);
      send_row(2);
      repeat (3) @(negedge clk);
      check("t2_hold_data2", row_data, tv[0].row);
      check("t2_hold_valid", 64'(row_valid), 64'd1);
      row_ready = 1'b1;
      @(negedge clk);
      row_ready = 1'b0;
      check("t2_valid_drop", 64'(row_valid), 64'd0);
      check("t2_overflow_sticky", 64'(row_overflow), 64'd1);

      reset = 1'b1;
      @(negedge clk);
      check("rst_clears_overflow", 64'(row_overflow), 64'd0);
      reset = 1'b0;
      repeat (2) @(negedge clk);

      // 3: accept in the same cycle a new row transfers
      send_row(0);
      repeat (3) @(negedge clk);
      for (int i = 0; i < 3; i++) send_beat(tv[3].beats[i]);
      rise_beat(tv[3].beats[3]);
      repeat (4) @(negedge clk);
      check("t3_old_still_held", row_data, tv[0].row);
      row_ready = 1'b1;
      @(negedge clk);
      row_ready = 1'b0;
      bus_clk   = 1'b0;
      check("t3_valid", 64'(row_valid), 64'd1);
      check("t3_data", row_data, tv[3].row);
      check("t3_overflow", 64'(row_overflow), 64'd0);

      // 4: partial row timeout
      err_pulses = 0;
      send_beat(tv[1].beats[0]);
      send_beat(tv[1].beats[1]);
      repeat (30) @(negedge clk);
      check("t4_error_pulses", 64'(err_pulses), 64'd1);
      check("t4_error_time", 64'(err_cyc - (rise_cyc + 4)), 64'd16);
      check("t4_valid_kept", 64'(row_valid), 64'd1);
      check("t4_data_kept", row_data, tv[3].row);
      check("t4_active", 64'(bus_active), 64'd0);
      row_ready = 1'b1;
      @(negedge clk);
      row_ready = 1'b0;
      send_row(2);
      repeat (3) @(negedge clk);
      check("t4_next_data", row_data, tv[2].row);
      check("t4_next_valid", 64'(row_valid), 64'd1);
      check("t4_no_more_err", 64'(err_pulses), 64'd1);

      // 5: reset mid-row
      send_beat(tv[0].beats[0]);
      send_beat(tv[0].beats[1]);
      check("t5_active_mid", 64'(bus_active), 64'd1);
      reset = 1'b1;
      #1;
      check("t5_valid_rst", 64'(row_valid), 64'd0);
      check("t5_data_rst", row_data, 64'd0);
      check("t5_active_rst", 64'(bus_active), 64'd0);
      repeat (2) @(negedge clk);
      reset = 1'b0;
      send_row(1);
      repeat (3) @(negedge clk);
      check("t5_data", row_data, tv[1].row);
      check("t5_valid", 64'(row_valid), 64'd1);

      // 6: back-to-back rows, consumer always ready
      row_ready = 1'b1;
      repeat (2) @(negedge clk);
      got.delete();
      err_pulses = 0;
      for (int k = 0; k < 4; k++) send_row(k);
      repeat (10) @(negedge clk);
      check("t6_count", 64'(got.size()), 64'd4);
      for (int k = 0; k < 4; k++) begin
         if (k < got.size()) check($sformatf("t6_row%0d", k), got[k], tv[k].row);
         else check($sformatf("t6_row%0d", k), 64'hX, tv[k].row);
      end
      check("t6_error", 64'(err_pulses), 64'd0);
      check("t6_overflow", 64'(row_overflow), 64'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
